intr_seq_ctrl: RTL

Interrupt entry/exit sequencer for the pipelined processor.
- Owns the interrupt-mode bit that selects the CCR's shadow flag bank.
- Stalls fetch, drains the pipeline, pushes the PC, redirects to the interrupt vector, and on RTI pops the PC and returns to normal mode.
- Sits beside the hazard unit; its outputs feed fetch PC muxing, the memory stage stack port and the CCR.

---
 rtl/intr_seq_ctrl_pkg.sv | 17 +
 rtl/intr_seq_ctrl.sv | 123 ++++++++++++
 2 files changed

// File: rtl/intr_seq_ctrl_pkg.sv
// Shared encodings for the interrupt entry/exit sequencer and the fetch unit's next-PC mux.
package intr_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRAIN  = 3'd1,
        PUSH   = 3'd2,
        VECTOR = 3'd3,
        ISR    = 3'd4,
        POP    = 3'd5
    } intr_state_t;

    localparam logic [1:0] PC_SEQ   = 2'b00;
    localparam logic [1:0] PC_STACK = 2'b01;
    localparam logic [1:0] PC_VEC   = 2'b10;

endpackage

// File: rtl/intr_seq_ctrl.sv
// Interrupt entry/exit sequencer: drains the pipe, pushes the return PC, vectors,
// and on RTI pops the PC back. Owns the interrupt-mode (shadow flag bank) bit.
module intr_seq_ctrl
    import intr_seq_ctrl_pkg::*;
#(
    parameter int PIPE_DEPTH = 4,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       intr_req,
    input  logic       rti_ex,
    input  logic       mem_ack,
    output logic       intr_mode,
    output logic       stall_fetch,
    output logic       flush,
    output logic       push_pc,
    output logic       pop_pc,
    output logic [1:0] pc_sel,
    output logic       flag_wr_block,
    output logic       intr_ack,
    output logic       spurious_rti
);

    localparam logic [CNT_W-1:0] LP_DRAIN_LOAD = CNT_W'(PIPE_DEPTH - 1);

    intr_state_t      r_state;
    intr_state_t      w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_spurious;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Loaded with PIPE_DEPTH-1 on entry so DRAIN dwells exactly PIPE_DEPTH cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (r_state == IDLE && intr_req) begin
            r_cnt <= LP_DRAIN_LOAD;
        end else if (r_state == DRAIN && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_spurious <= 1'b0;
        end else if (r_state == IDLE && rti_ex) begin
            r_spurious <= 1'b1;
        end
    end

    assign spurious_rti = r_spurious;

    always_comb begin
        w_next        = r_state;
        intr_mode     = 1'b0;
        stall_fetch   = 1'b0;
        flush         = 1'b0;
        push_pc       = 1'b0;
        pop_pc        = 1'b0;
        pc_sel        = PC_SEQ;
        flag_wr_block = 1'b0;
        intr_ack      = 1'b0;
        case (r_state)
            IDLE: begin
                if (intr_req) begin
                    w_next = DRAIN;
                end
            end
            DRAIN: begin
                stall_fetch = 1'b1;
                if (r_cnt == '0) begin
                    w_next = PUSH;
                end
            end
            PUSH: begin
                stall_fetch   = 1'b1;
                push_pc       = 1'b1;
                flag_wr_block = 1'b1;
                if (mem_ack) begin
                    w_next = VECTOR;
                end
            end
            VECTOR: begin
                intr_mode     = 1'b1;
                pc_sel        = PC_VEC;
                flush         = 1'b1;
                intr_ack      = 1'b1;
                flag_wr_block = 1'b1;
                w_next        = ISR;
            end
            ISR: begin
                intr_mode = 1'b1;
                if (rti_ex) begin
                    w_next = POP;
                end
            end
            POP: begin
                intr_mode     = 1'b1;
                stall_fetch   = 1'b1;
                pop_pc        = 1'b1;
                flag_wr_block = 1'b1;
                // Redirect to the popped PC in the same cycle the stack port accepts.
                if (mem_ack) begin
                    pc_sel = PC_STACK;
                    flush  = 1'b1;
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

endmodule
